// File: rtl/data_mem_init.sv
// Single-write-port data memory with a self-sequencing init engine: optional zero-fill,
// then a fixed constant table load, then RUN with port A read/write and a read-only port B.
module data_mem_init #(
   parameter int unsigned W        = 8,
   parameter int unsigned A        = 8,
   parameter int unsigned RD_LAT   = 0,
   parameter int unsigned CLEAR_EN = 1
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         WriteEn,
   input  logic [A-1:0] DataAddress,
   input  logic [W-1:0] DataIn,
   output logic [W-1:0] DataOut,
   input  logic [A-1:0] ReadAddrB,
   output logic [W-1:0] DataOutB,
   output logic         Ready,
   output logic         WrErr
);

   typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_RUN} state_t;

   localparam int unsigned DEPTH   = 1 << A;
   localparam int unsigned TBL_LEN = 12;
   localparam state_t      S_INIT  = (CLEAR_EN != 0) ? S_CLEAR : S_LOAD;

   logic [W-1:0] r_core [DEPTH];

   state_t       r_state, w_state_nxt;
   logic [A:0]   r_cnt, w_cnt_nxt;
   logic         r_ready, w_ready_nxt;
   logic         r_wrerr;

   logic         w_mem_we;
   logic [A-1:0] w_mem_addr;
   logic [W-1:0] w_mem_wdata;
   logic [7:0]   w_tbl_addr8;
   logic [7:0]   w_tbl_data8;

   // Constant init table, packed as {address, data}.
   function automatic logic [15:0] tbl_entry(input int unsigned idx);
      case (idx)
         0:       tbl_entry = {8'd128, 8'h01};
         1:       tbl_entry = {8'd129, 8'hFF};
         2:       tbl_entry = {8'd130, 8'h40};
         3:       tbl_entry = {8'd200, 8'h60};
         4:       tbl_entry = {8'd201, 8'h48};
         5:       tbl_entry = {8'd202, 8'h78};
         6:       tbl_entry = {8'd203, 8'h72};
         7:       tbl_entry = {8'd204, 8'h6A};
         8:       tbl_entry = {8'd205, 8'h69};
         9:       tbl_entry = {8'd206, 8'h5C};
         10:      tbl_entry = {8'd207, 8'h7E};
         11:      tbl_entry = {8'd208, 8'h7B};
         default: tbl_entry = '0;
      endcase
   endfunction

   function automatic logic [A-1:0] fit_addr(input logic [7:0] a);
      fit_addr = '0;
      for (int unsigned i = 0; i < A; i++)
         fit_addr[i] = (i < 8) ? a[i % 8] : 1'b0;
   endfunction

   function automatic logic [W-1:0] fit_data(input logic [7:0] d);
      fit_data = '0;
      for (int unsigned i = 0; i < W; i++)
         fit_data[i] = (i < 8) ? d[i % 8] : 1'b0;
   endfunction

   // Table entries beyond the configured depth consume their cycle but never write.
   function automatic logic addr_fits(input logic [7:0] a);
      addr_fits = 1'b1;
      for (int unsigned i = 0; i < 8; i++)
         if (i >= A && a[i]) addr_fits = 1'b0;
   endfunction

   assign {w_tbl_addr8, w_tbl_data8} = tbl_entry(32'(r_cnt));

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= S_INIT;
         r_cnt   <= '0;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ready <= w_ready_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ready_nxt = r_ready;
      w_mem_we    = 1'b0;
      w_mem_addr  = DataAddress;
      w_mem_wdata = DataIn;
      case (r_state)
         S_CLEAR: begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_cnt[A-1:0];
            w_mem_wdata = '0;
            if (r_cnt[A-1:0] == '1) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_LOAD;
            end else begin
               w_cnt_nxt = r_cnt + (A+1)'(1);
            end
         end
         S_LOAD: begin
            w_mem_we    = addr_fits(w_tbl_addr8);
            w_mem_addr  = fit_addr(w_tbl_addr8);
            w_mem_wdata = fit_data(w_tbl_data8);
            w_cnt_nxt   = r_cnt + (A+1)'(1);
            if (r_cnt == (A+1)'(TBL_LEN - 1)) begin
               w_state_nxt = S_RUN;
               w_ready_nxt = 1'b1;
            end
         end
         S_RUN: begin
            w_mem_we = WriteEn;
         end
         default: begin
            w_state_nxt = S_INIT;
         end
      endcase
   end

   // Memory keeps its contents while Reset is held.
   always_ff @(posedge Clk) begin
      if (!Reset && w_mem_we)
         r_core[w_mem_addr] <= w_mem_wdata;
   end

   always_ff @(posedge Clk) begin
      if (Reset)
         r_wrerr <= 1'b0;
      else if (WriteEn && !r_ready)
         r_wrerr <= 1'b1;
   end

   assign Ready    = r_ready;
   assign WrErr    = r_wrerr;
   assign DataOutB = r_core[ReadAddrB];

   generate
      if (RD_LAT != 0) begin : g_rd_reg
         logic [W-1:0] r_dout;
         always_ff @(posedge Clk) begin
            if (Reset)
               r_dout <= '0;
            else
               r_dout <= r_core[DataAddress];
         end
         assign DataOut = r_ready ? r_dout : '0;
      end else begin : g_rd_comb
         assign DataOut = r_ready ? r_core[DataAddress] : '0;
      end
   endgenerate

endmodule

// File: tb/tb_data_mem_init.sv
// Bench for data_mem_init: three configurations driven against an edge-count reference model,
// with a per-cycle compare process plus directed literal checks.
module tb_data_mem_init;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   // A=8 group (combinational and registered port A share stimulus)
   logic       rst, we;
   logic [7:0] addr, din, rab;
   logic [7:0] dout0, dout1, doutb0, doutb1;
   logic       rdy0, rdy1, err0, err1;

   // A=6, no clear
   logic       rst6, we6;
   logic [5:0] addr6, rab6;
   logic [7:0] din6, dout6, doutb6;
   logic       rdy6, err6;

   int n_chk  = 0;
   int n_fail = 0;

   data_mem_init #(.W(8), .A(8), .RD_LAT(0), .CLEAR_EN(1)) u_comb (
      .Clk(Clk), .Reset(rst), .WriteEn(we), .DataAddress(addr), .DataIn(din),
      .DataOut(dout0), .ReadAddrB(rab), .DataOutB(doutb0), .Ready(rdy0), .WrErr(err0));

   data_mem_init #(.W(8), .A(8), .RD_LAT(1), .CLEAR_EN(1)) u_reg (
      .Clk(Clk), .Reset(rst), .WriteEn(we), .DataAddress(addr), .DataIn(din),
      .DataOut(dout1), .ReadAddrB(rab), .DataOutB(doutb1), .Ready(rdy1), .WrErr(err1));

   data_mem_init #(.W(8), .A(6), .RD_LAT(0), .CLEAR_EN(0)) u_a6 (
      .Clk(Clk), .Reset(rst6), .WriteEn(we6), .DataAddress(addr6), .DataIn(din6),
      .DataOut(dout6), .ReadAddrB(rab6), .DataOutB(doutb6), .Ready(rdy6), .WrErr(err6));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   logic [7:0] tbl_a [12] = '{8'd128, 8'd129, 8'd130, 8'd200, 8'd201, 8'd202,
                              8'd203, 8'd204, 8'd205, 8'd206, 8'd207, 8'd208};
   logic [7:0] tbl_d [12] = '{8'h01, 8'hFF, 8'h40, 8'h60, 8'h48, 8'h78,
                              8'h72, 8'h6A, 8'h69, 8'h5C, 8'h7E, 8'h7B};

   logic [7:0] m8 [256];
   bit         v8 [256];
   int         k8;
   bit         rdy8, err8, dregv8;
   logic [7:0] dreg8;

   // Init is modelled purely by the number of edges since Reset fell:
   // edges 1..256 zero entry k-1, edges 257..268 apply table entry k-257.
   always @(posedge Clk) begin : mdl8
      int nk;
      int j;
      if (rst) begin
         k8 <= 0; rdy8 <= 1'b0; err8 <= 1'b0; dreg8 <= '0; dregv8 <= 1'b1;
      end else begin
         dreg8  <= m8[addr];
         dregv8 <= v8[addr];
         if (we && !rdy8) err8 <= 1'b1;
         if (rdy8) begin
            if (we) begin m8[addr] <= din; v8[addr] <= 1'b1; end
         end else begin
            nk = k8 + 1;
            k8 <= nk;
            if (nk <= 256) begin
               m8[nk-1] <= '0; v8[nk-1] <= 1'b1;
            end else begin
               j = nk - 257;
               m8[tbl_a[j]] <= tbl_d[j];
               v8[tbl_a[j]] <= 1'b1;
               if (j == 11) rdy8 <= 1'b1;
            end
         end
      end
   end

   logic [7:0] m6 [64];
   bit         v6 [64];
   int         k6;
   bit         rdy6m, err6m;

   always @(posedge Clk) begin : mdl6
      int nk;
      if (rst6) begin
         k6 <= 0; rdy6m <= 1'b0; err6m <= 1'b0;
      end else begin
         if (we6 && !rdy6m) err6m <= 1'b1;
         if (rdy6m) begin
            if (we6) begin m6[addr6] <= din6; v6[addr6] <= 1'b1; end
         end else begin
            nk = k6 + 1;
            k6 <= nk;
            if (tbl_a[nk-1] < 8'd64) begin
               m6[tbl_a[nk-1][5:0]] <= tbl_d[nk-1];
               v6[tbl_a[nk-1][5:0]] <= 1'b1;
            end
            if (nk == 12) rdy6m <= 1'b1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge Clk) begin
      chk("ready_comb", rdy0, rdy8);
      chk("ready_reg",  rdy1, rdy8);
      chk("wrerr_comb", err0, err8);
      chk("wrerr_reg",  err1, err8);
      if (v8[rab]) begin
         chk("portB_comb", doutb0, m8[rab]);
         chk("portB_reg",  doutb1, m8[rab]);
      end
      if (!rdy8) begin
         chk("doutA_comb_init", dout0, 0);
         chk("doutA_reg_init",  dout1, 0);
      end else begin
         if (v8[addr]) chk("doutA_comb", dout0, m8[addr]);
         if (dregv8)   chk("doutA_reg",  dout1, dreg8);
      end
      chk("ready_a6", rdy6, rdy6m);
      chk("wrerr_a6", err6, err6m);
      if (v6[rab6]) chk("portB_a6", doutb6, m6[rab6]);
      if (!rdy6m) chk("doutA_a6_init", dout6, 0);
      else if (v6[addr6]) chk("doutA_a6", dout6, m6[addr6]);
   end

   // Counts edges after Reset fell until Ready; optional illegal write at edge 100.
   task automatic wait_ready8(input int exp_len, input bit poke);
      int n = 0;
      for (int c = 1; c <= exp_len + 20 && n == 0; c++) begin
         we   = poke && (c == 100);
         addr = (poke && c == 100) ? 8'd3 : 8'($urandom);
         din  = 8'hAA;
         rab  = 8'($urandom);
         tick();
         if (rdy0) n = c;
      end
      we = 1'b0;
      chk("init_len", n, exp_len);
   endtask

   task automatic wait_ready6(input int exp_len);
      int n = 0;
      for (int c = 1; c <= exp_len + 20 && n == 0; c++) begin
         rab6 = 6'($urandom);
         tick();
         if (rdy6) n = c;
      end
      chk("init_len_a6", n, exp_len);
   endtask

   logic [7:0] pat [64];
   logic [7:0] lit_a [6] = '{8'd128, 8'd129, 8'd130, 8'd208, 8'd0, 8'd255};
   logic [7:0] lit_d [6] = '{8'h01, 8'hFF, 8'h40, 8'h7B, 8'h00, 8'h00};

   initial begin
      rst = 1'b1; we = 1'b0; addr = '0; din = '0; rab = '0;
      rst6 = 1'b1; we6 = 1'b0; addr6 = '0; din6 = '0; rab6 = '0;
      repeat (3) tick();
      chk("reset_ready", rdy0, 0);
      chk("reset_wrerr", err0, 0);
      chk("reset_dout_reg", dout1, 0);

      // full init with an illegal write during CLEAR
      rst = 1'b0;
      wait_ready8(268, 1'b1);
      chk("wrerr_sticky", err0, 1);
      for (int i = 0; i < 6; i++) begin
         rab = lit_a[i];
         #1;
         chk("tbl_portB", doutb0, lit_d[i]);
      end
      addr = 8'd3;
      #1;
      chk("dropped_write", dout0, 8'h00);

      // RUN write, both read latencies
      tick();
      addr = 8'd7; din = 8'h5A; we = 1'b1;
      #1;
      chk("wr7_before", dout0, 8'h00);
      tick();
      chk("wr7_comb_after", dout0, 8'h5A);
      chk("wr7_reg_old", dout1, 8'h00);
      we = 1'b0;
      tick();
      chk("wr7_reg_new", dout1, 8'h5A);

      // port B read-during-write
      rab = 8'd200; addr = 8'd200; din = 8'h11; we = 1'b1;
      #1;
      chk("rdw_portB_old", doutb0, 8'h60);
      tick();
      we = 1'b0;
      chk("rdw_portB_new", doutb0, 8'h11);

      repeat (300) begin
         we   = 1'($urandom_range(0, 1));
         addr = 8'($urandom);
         din  = 8'($urandom);
         rab  = ($urandom_range(0, 3) == 0) ? addr : 8'($urandom);
         tick();
      end
      we = 1'b0;

      // reset from RUN, then again mid-CLEAR
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("wrerr_cleared", err0, 0);
      chk("ready_dropped", rdy0, 0);
      repeat (100) begin
         rab = 8'($urandom);
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("ready_mid_clear", rdy0, 0);
      wait_ready8(268, 1'b0);

      // A=6, no clear
      rst6 = 1'b0;
      wait_ready6(12);
      for (int i = 0; i < 64; i++) begin
         pat[i] = 8'($urandom);
         addr6 = 6'(i); din6 = pat[i]; we6 = 1'b1;
         tick();
      end
      we6 = 1'b0;
      for (int i = 0; i < 64; i++) begin
         addr6 = 6'(i); rab6 = 6'(63 - i);
         #1;
         chk("a6_readback", dout6, pat[i]);
         tick();
      end
      rst6 = 1'b1;
      tick();
      rst6 = 1'b0;
      wait_ready6(12);
      for (int i = 0; i < 64; i++) begin
         rab6 = 6'(i);
         #1;
         chk("a6_load_untouched", doutb6, pat[i]);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
